reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Architectural register file with rename tags. It sits between the Decoder, the RoB and the RS/LSB.
- It takes issue-time renames (rd -> rob_id) and commit-time writebacks from the RoB.
- It answers Decoder operand queries with either a ready value or the producing rob_id.
- It resolves in-flight operands by querying the RoB's instant value port (get_rob_id/get_value/get_ready).

Parameters:
- ROB_SIZE_WIDTH, 3, width of a RoB index (RoB depth = 2^ROB_SIZE_WIDTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous and active-low (asserted when 0).
- rdy  input  1  global ready; state holds when 0.
- clear  input  1  misprediction flush; effective only when rdy=1.
- issue_valid  input  1  rename request this cycle.
- issue_rd  input  5  destination register being renamed.
- issue_rob_id  input  ROB_SIZE_WIDTH  RoB entry that will produce issue_rd.
- commit_valid  input  1  RoB retires a register-writing instruction.
- commit_rd  input  5  register written at commit.
- commit_rob_id  input  ROB_SIZE_WIDTH  RoB entry being retired.
- commit_value  input  32  retired value.
- query_rs1, query_rs2  input  5 each  Decoder source operand indices.
- rs1_value, rs2_value  output  32 each  operand value; valid when the matching busy output is 0.
- rs1_busy, rs2_busy  output  1 each  1 = operand still pending.
- rs1_rob_id, rs2_rob_id  output  ROB_SIZE_WIDTH each  producing RoB entry when busy.
- get_rob_id1, get_rob_id2  output  ROB_SIZE_WIDTH each  tag of query_rs1/query_rs2, sent to the RoB.
- get_ready1, get_ready2  input  1 each  RoB reports that tag's value is available now.
- get_value1, get_value2  input  32 each  RoB value for get_rob_id1/get_rob_id2.

Behaviour:
- State: data[0..31] (32b), busy[0..31], tag[0..31] (ROB_SIZE_WIDTH).
- Reset: rst=0 at posedge -> all data, busy and tag cleared to 0. Reset overrides rdy/clear/issue/commit.
- rdy=0: no state change; query outputs still driven combinationally.
- Commit (rdy=1, commit_valid=1, commit_rd!=0):
  - data[commit_rd] <= commit_value.
  - busy[commit_rd] <= 0 only if busy[commit_rd]=1 and tag[commit_rd]==commit_rob_id.
  - A stale commit (tag mismatch) updates data but leaves busy/tag untouched.
- Issue (rdy=1, issue_valid=1, issue_rd!=0, clear=0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_id.
- Simultaneous issue and commit to the same rd: commit writes data; issue wins for busy/tag (busy=1, tag=new).
- clear && rdy: the commit that cycle is still applied to data; every busy cleared to 0; issue ignored; tags unchanged (don't-care).
- x0: never written, never busy; issue/commit with rd=0 is a no-op for x0 state.
- Query path, combinational, identical for rs1/rs2. Queries see pre-issue state, so the same-cycle issue of an instruction does not rename its own sources. Priority order:
  1. rs==0 -> value 0, busy 0, rob_id 0.
  2. busy[rs]=0 -> value data[rs], busy 0.
  3. busy[rs]=1, commit_valid, commit_rd==rs, commit_rob_id==tag[rs] -> value commit_value, busy 0.
  4. busy[rs]=1, get_readyN=1 -> value get_valueN, busy 0.
  5. Otherwise -> value 0, busy 1, rob_id tag[rs].
- get_rob_idN = tag[query_rsN] at all times, whether or not the register is busy.
- Latency: issue/commit effects visible in stored state the cycle after the posedge; commit is forwarded to queries in the same cycle.

Test Plan:
1. Reset: drive rst=0 for 1 cycle with issue_valid=1 -> every query returns value 0, busy 0; issue ignored.
2. Rename then retire:
   - Issue rd=5, rob 3 -> next cycle query_rs1=5 gives busy 1, rs1_rob_id 3, get_rob_id1 3.
   - Commit rd=5, rob 3, value 0x1234 -> same cycle rs1_value 0x1234, busy 0; next cycle data 0x1234, busy 0.
3. Stale commit and same-cycle collision:
   - Issue rd=7 rob 2, then rd=7 rob 4; commit rd=7 rob 2 value 0xAA -> data[7]=0xAA, busy 1, tag 4.
   - Issue rd=9 rob 6 in the same cycle as commit rd=9 rob 1 -> busy 1, tag 6.
4. RoB forwarding: rd=10 busy with tag 5, query_rs2=10, get_ready2=1, get_value2=0x55 -> rs2_value 0x55, rs2_busy 0, get_rob_id2=5.
5. x0: issue rd=0 rob 1, then commit rd=0 value 5 -> query 0 returns value 0, busy 0.
6. Flush and stall:
   - Busy x1, x2, x3; assert clear with rdy=1 and commit rd=3 value 9 -> all busy 0, data[3]=9.
   - Repeat with rdy=0 -> nothing changes.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with rename tags: issue-time renames, commit-time
// writebacks, and two operand query ports that forward commits and RoB values.
module reg_file_rd_port #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic [4:0]                rs,
  input  logic [31:0]               data_sel,
  input  logic                      busy_sel,
  input  logic [ROB_SIZE_WIDTH-1:0] tag_sel,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic                      get_ready,
  input  logic [31:0]               get_value,
  output logic [31:0]               value,
  output logic                      busy,
  output logic [ROB_SIZE_WIDTH-1:0] rob_id
);
  always_comb begin
    value  = '0;
    busy   = 1'b0;
    rob_id = '0;
    if (rs != 5'd0) begin
      if (!busy_sel)
        value = data_sel;
      else if (commit_valid && commit_rd == rs && commit_rob_id == tag_sel)
        value = commit_value;
      else if (get_ready)
        value = get_value;
      else begin
        busy   = 1'b1;
        rob_id = tag_sel;
      end
    end
  end
endmodule

module reg_file #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                query_rs1,
  input  logic [4:0]                query_rs2,
  output logic [31:0]               rs1_value,
  output logic [31:0]               rs2_value,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [ROB_SIZE_WIDTH-1:0] rs1_rob_id,
  output logic [ROB_SIZE_WIDTH-1:0] rs2_rob_id,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
  input  logic                      get_ready1,
  input  logic                      get_ready2,
  input  logic [31:0]               get_value1,
  input  logic [31:0]               get_value2
);
  localparam int NUM_PORTS = 2;

  logic [31:0][31:0]               data_q, data_d;
  logic [31:0]                     busy_q, busy_d;
  logic [31:0][ROB_SIZE_WIDTH-1:0] tag_q, tag_d;

  // Commit resolves busy only against the pre-issue tag; a same-cycle issue
  // to the same register then re-arms busy with the new tag.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit_valid && commit_rd != 5'd0) begin
        data_d[commit_rd] = commit_value;
        if (busy_q[commit_rd] && tag_q[commit_rd] == commit_rob_id)
          busy_d[commit_rd] = 1'b0;
      end
      if (clear)
        busy_d = '0;
      else if (issue_valid && issue_rd != 5'd0) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  logic [NUM_PORTS-1:0][4:0]                q_rs;
  logic [NUM_PORTS-1:0]                     q_ready, q_busy;
  logic [NUM_PORTS-1:0][31:0]               q_get_value, q_value;
  logic [NUM_PORTS-1:0][ROB_SIZE_WIDTH-1:0] q_rob_id;

  assign q_rs        = {query_rs2, query_rs1};
  assign q_ready     = {get_ready2, get_ready1};
  assign q_get_value = {get_value2, get_value1};

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      reg_file_rd_port #(.ROB_SIZE_WIDTH(ROB_SIZE_WIDTH)) u_port (
        .rs            (q_rs[g]),
        .data_sel      (data_q[q_rs[g]]),
        .busy_sel      (busy_q[q_rs[g]]),
        .tag_sel       (tag_q[q_rs[g]]),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .get_ready     (q_ready[g]),
        .get_value     (q_get_value[g]),
        .value         (q_value[g]),
        .busy          (q_busy[g]),
        .rob_id        (q_rob_id[g])
      );
    end
  endgenerate

  assign rs1_value   = q_value[0];
  assign rs2_value   = q_value[1];
  assign rs1_busy    = q_busy[0];
  assign rs2_busy    = q_busy[1];
  assign rs1_rob_id  = q_rob_id[0];
  assign rs2_rob_id  = q_rob_id[1];
  assign get_rob_id1 = tag_q[query_rs1];
  assign get_rob_id2 = tag_q[query_rs2];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based model of the architectural/rename state.
module tb_reg_file;
  localparam int W = 3;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [W-1:0]  issue_rob_id;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [W-1:0]  commit_rob_id;
  logic [31:0]   commit_value;
  logic [4:0]    query_rs1, query_rs2;
  logic [31:0]   rs1_value, rs2_value;
  logic          rs1_busy, rs2_busy;
  logic [W-1:0]  rs1_rob_id, rs2_rob_id, get_rob_id1, get_rob_id2;
  logic          get_ready1, get_ready2;
  logic [31:0]   get_value1, get_value2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  m_data [32];
  logic         m_busy [32];
  logic [W-1:0] m_tag  [32];

  reg_file #(.ROB_SIZE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_value(commit_value), .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .get_value1(get_value1), .get_value2(get_value2)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
    get_ready1 = 1'b0; get_ready2 = 1'b0; get_value1 = '0; get_value2 = '0;
  endtask

  // Model update from the currently driven inputs, then advance one clock.
  task automatic tick();
    logic hit;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
    end else if (rdy) begin
      hit = commit_valid && commit_rd != 0 && m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id;
      if (commit_valid && commit_rd != 0) m_data[commit_rd] = commit_value;
      if (hit) m_busy[commit_rd] = 1'b0;
      if (clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_id;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic void exp_q(input logic [4:0] rs, input logic gr, input logic [31:0] gv,
                                output logic [31:0] v, output logic b, output logic [W-1:0] id);
    v = 32'd0; b = 1'b0; id = '0;
    if (rs == 0) return;
    if (!m_busy[rs]) v = m_data[rs];
    else if (commit_valid && commit_rd == rs && commit_rob_id == m_tag[rs]) v = commit_value;
    else if (gr) v = gv;
    else begin b = 1'b1; id = m_tag[rs]; end
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b0; issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 3'd3;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      query_rs1 = 5'(i); query_rs2 = 5'(31 - i); #1;
      n_cmp++;
      if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs2_value !== 32'd0 || rs2_busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_q%0d: v1=%h b1=%b v2=%h b2=%b, want all 0", i, rs1_value, rs1_busy, rs2_value, rs2_busy);
      end
    end
  endtask

  task automatic test_rename_retire();
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 3'd3;
    tick();
    idle(); query_rs1 = 5'd5; #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs1_rob_id !== 3'd3 || get_rob_id1 !== 3'd3) begin
      n_err++;
      $display("FAIL rename: busy=%b rob=%0d get=%0d, want 1/3/3", rs1_busy, rs1_rob_id, get_rob_id1);
    end
    commit_valid = 1'b1; commit_rd = 5'd5; commit_rob_id = 3'd3; commit_value = 32'h1234; #1;
    n_cmp++;
    if (rs1_value !== 32'h1234 || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL commit_fwd: v=%h b=%b, want 1234/0", rs1_value, rs1_busy);
    end
    tick();
    idle(); query_rs1 = 5'd5; #1;
    n_cmp++;
    if (rs1_value !== 32'h1234 || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL retire: v=%h b=%b, want 1234/0", rs1_value, rs1_busy);
    end
  endtask

  task automatic test_stale_collision();
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; issue_rob_id = 3'd2; tick();
    issue_rob_id = 3'd4; tick();
    idle(); commit_valid = 1'b1; commit_rd = 5'd7; commit_rob_id = 3'd2; commit_value = 32'hAA;
    query_rs1 = 5'd7; #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs1_rob_id !== 3'd4) begin
      n_err++;
      $display("FAIL stale_no_fwd: busy=%b rob=%0d, want 1/4", rs1_busy, rs1_rob_id);
    end
    tick();
    idle(); query_rs1 = 5'd7; #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs1_rob_id !== 3'd4 || get_rob_id1 !== 3'd4) begin
      n_err++;
      $display("FAIL stale_commit: busy=%b rob=%0d get=%0d, want 1/4/4", rs1_busy, rs1_rob_id, get_rob_id1);
    end
    clear = 1'b1; tick();
    idle(); query_rs1 = 5'd7; #1;
    n_cmp++;
    if (rs1_value !== 32'hAA || rs1_busy !== 1'b0) begin
      n_err++;
      $display("FAIL stale_data: v=%h b=%b, want aa/0", rs1_value, rs1_busy);
    end
    // matching commit and re-issue of the same register in one cycle
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_id = 3'd1; tick();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_id = 3'd6;
    commit_valid = 1'b1; commit_rd = 5'd9; commit_rob_id = 3'd1; commit_value = 32'h99;
    tick();
    idle(); query_rs2 = 5'd9; #1;
    n_cmp++;
    if (rs2_busy !== 1'b1 || rs2_rob_id !== 3'd6) begin
      n_err++;
      $display("FAIL collision: busy=%b rob=%0d, want 1/6", rs2_busy, rs2_rob_id);
    end
  endtask

  task automatic test_forward();
    idle(); issue_valid = 1'b1; issue_rd = 5'd10; issue_rob_id = 3'd5; tick();
    idle(); query_rs2 = 5'd10; #1;
    n_cmp++;
    if (rs2_busy !== 1'b1 || rs2_rob_id !== 3'd5 || rs2_value !== 32'd0) begin
      n_err++;
      $display("FAIL fwd_pending: v=%h b=%b rob=%0d, want 0/1/5", rs2_value, rs2_busy, rs2_rob_id);
    end
    get_ready2 = 1'b1; get_value2 = 32'h55; #1;
    n_cmp++;
    if (rs2_value !== 32'h55 || rs2_busy !== 1'b0 || get_rob_id2 !== 3'd5) begin
      n_err++;
      $display("FAIL rob_fwd: v=%h b=%b get=%0d, want 55/0/5", rs2_value, rs2_busy, get_rob_id2);
    end
  endtask

  task automatic test_x0();
    idle(); issue_valid = 1'b1; issue_rd = 5'd0; issue_rob_id = 3'd1; tick();
    idle(); commit_valid = 1'b1; commit_rd = 5'd0; commit_rob_id = 3'd1; commit_value = 32'd5; tick();
    idle(); query_rs1 = 5'd0; query_rs2 = 5'd0; #1;
    n_cmp++;
    if (rs1_value !== 32'd0 || rs1_busy !== 1'b0 || rs1_rob_id !== 3'd0 || get_rob_id1 !== 3'd0 ||
        rs2_value !== 32'd0 || rs2_busy !== 1'b0) begin
      n_err++;
      $display("FAIL x0: v=%h b=%b rob=%0d get=%0d, want all 0", rs1_value, rs1_busy, rs1_rob_id, get_rob_id1);
    end
  endtask

  task automatic test_flush_stall();
    idle();
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r); issue_rob_id = W'(r); tick();
    end
    idle(); rdy = 1'b0; clear = 1'b1; commit_valid = 1'b1; commit_rd = 5'd3;
    commit_rob_id = 3'd7; commit_value = 32'd9; issue_valid = 1'b1; issue_rd = 5'd4; tick();
    idle();
    query_rs1 = 5'd3; query_rs2 = 5'd1; #1;
    n_cmp++;
    if (rs1_busy !== 1'b1 || rs1_rob_id !== 3'd3 || rs2_busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall: b3=%b rob3=%0d b1=%b, want 1/3/1", rs1_busy, rs1_rob_id, rs2_busy);
    end
    query_rs1 = 5'd4; #1;
    n_cmp++;
    if (rs1_busy !== 1'b0 || rs1_value !== 32'd0) begin
      n_err++;
      $display("FAIL stall_issue: b=%b v=%h, want 0/0", rs1_busy, rs1_value);
    end
    clear = 1'b1; commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_id = 3'd7; commit_value = 32'd9;
    issue_valid = 1'b1; issue_rd = 5'd2; issue_rob_id = 3'd5; tick();
    idle();
    for (int r = 1; r <= 3; r++) begin
      query_rs1 = 5'(r); #1;
      n_cmp++;
      if (rs1_busy !== 1'b0 || rs1_value !== (r == 3 ? 32'd9 : 32'd0)) begin
        n_err++;
        $display("FAIL flush_x%0d: b=%b v=%h, want 0/%h", r, rs1_busy, rs1_value, (r == 3 ? 32'd9 : 32'd0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ev1, ev2; logic eb1, eb2; logic [W-1:0] ei1, ei2;
    for (int c = 0; c < 400; c++) begin
      idle();
      rst          = ($urandom_range(99) != 0);
      rdy          = ($urandom_range(9) != 0);
      clear        = ($urandom_range(19) == 0);
      issue_valid  = $urandom_range(1);
      issue_rd     = 5'($urandom_range(7));
      issue_rob_id = W'($urandom);
      commit_valid = $urandom_range(1);
      commit_rd    = 5'($urandom_range(7));
      commit_rob_id = $urandom_range(1) ? m_tag[commit_rd] : W'($urandom);
      commit_value = $urandom;
      query_rs1    = 5'($urandom_range(7));
      query_rs2    = 5'($urandom_range(7));
      get_ready1   = ($urandom_range(3) == 0);
      get_ready2   = ($urandom_range(3) == 0);
      get_value1   = $urandom;
      get_value2   = $urandom;
      #1;
      exp_q(query_rs1, get_ready1, get_value1, ev1, eb1, ei1);
      exp_q(query_rs2, get_ready2, get_value2, ev2, eb2, ei2);
      n_cmp++;
      if (rs1_value !== ev1 || rs1_busy !== eb1 || (eb1 && rs1_rob_id !== ei1) || get_rob_id1 !== m_tag[query_rs1]) begin
        n_err++;
        $display("FAIL rnd%0d_rs1 x%0d: v=%h b=%b rob=%0d get=%0d, want %h/%b/%0d/%0d", c, query_rs1,
                 rs1_value, rs1_busy, rs1_rob_id, get_rob_id1, ev1, eb1, ei1, m_tag[query_rs1]);
      end
      n_cmp++;
      if (rs2_value !== ev2 || rs2_busy !== eb2 || (eb2 && rs2_rob_id !== ei2) || get_rob_id2 !== m_tag[query_rs2]) begin
        n_err++;
        $display("FAIL rnd%0d_rs2 x%0d: v=%h b=%b rob=%0d get=%0d, want %h/%b/%0d/%0d", c, query_rs2,
                 rs2_value, rs2_busy, rs2_rob_id, get_rob_id2, ev2, eb2, ei2, m_tag[query_rs2]);
      end
      tick();
    end
  endtask

  initial begin
    idle(); query_rs1 = '0; query_rs2 = '0;
    @(posedge clk); #1;
    test_reset();
    test_rename_retire();
    test_stale_collision();
    test_forward();
    test_x0();
    test_flush_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
